// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan controller.
//   WIDTH    : number of mux channels scanned (fixed at 16)
//   SEL_W    : select width, log2(WIDTH)
//   SEL_LAST : index of the final channel in a scan
//   scan_state_t : controller state encoding
package mux_scan_pkg;

    localparam int WIDTH = 16;
    localparam int SEL_W = 4;

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } scan_state_t;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Result stream from the scan controller to its consumer.
//   data_out : assembled scan word (bit i = mux output while sel==i)
//   valid    : data_out holds a completed scan
//   ready    : consumer accepts data_out
// master = controller side, slave = consumer side.
interface mux_scan_ctrl_if;
    import mux_scan_pkg::*;

    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             ready;

    modport master (
        output data_out,
        output valid,
        input  ready
    );

    modport slave (
        input  data_out,
        input  valid,
        output ready
    );

endinterface

// File: rtl/mux_scan_ctrl_dwell_cnt.sv
// Loadable down-counter timing the dwell on each mux channel.
//   clk   : clock
//   rst_n : asynchronous active-low reset (count -> 0)
//   load  : reload the count with LOAD_VAL (wins over dec)
//   dec   : decrement by one, saturating at zero
//   zero  : count is zero, i.e. the dwell has expired
module scan_dwell_cnt #(
    parameter int                CNT_W    = 4,
    parameter logic [CNT_W-1:0]  LOAD_VAL = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= LOAD_VAL;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sequential select driver and sample collector for an external 16:1 mux.
// Steps sel through channels 0..15, dwelling SETTLE+1 cycles on each, samples
// y_in at the end of each dwell and presents the assembled word on a
// valid/ready stream.
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   start : request a scan (honoured in IDLE, or in HOLD together with ready)
//   abort : cancel an in-progress scan
//   sel   : mux select
//   y_in  : mux output
//   busy  : high while scanning
//   bus   : result stream (data_out / valid / ready)
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [SEL_W-1:0]  sel,
    input  logic              y_in,
    output logic              busy,
    mux_scan_ctrl_if.master   bus
);

    scan_state_t       state_reg;
    logic [SEL_W-1:0]  sel_reg;
    logic [WIDTH-2:0]  shadow_reg;
    logic [WIDTH-1:0]  data_out_reg;
    logic              valid_reg;
    logic              busy_reg;

    logic dwell_zero;
    logic dwell_load;
    logic dwell_dec;
    logic sample_en;
    logic last_ch;

    assign last_ch = (sel_reg == SEL_LAST);

    // End of dwell on the current channel, scan not being cancelled.
    assign sample_en = (state_reg == SCAN) && !abort && dwell_zero;

    // The dwell restarts whenever a new channel is presented: on scan
    // entry (from IDLE or a back-to-back handshake) and on each step.
    assign dwell_load = ((state_reg == IDLE) && start)
                      || (sample_en && !last_ch)
                      || ((state_reg == HOLD) && bus.ready && start);

    assign dwell_dec = (state_reg == SCAN) && !abort && !dwell_zero;

    scan_dwell_cnt #(
        .CNT_W    (SEL_W),
        .LOAD_VAL (SEL_W'(SETTLE))
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (dwell_load),
        .dec   (dwell_dec),
        .zero  (dwell_zero)
    );

    // Shadow bits 0..14; bit 15 goes straight into data_out on completion.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shadow
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_reg[gi] <= 1'b0;
                end else if (sample_en && (sel_reg == SEL_W'(gi))) begin
                    shadow_reg[gi] <= y_in;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            sel_reg      <= '0;
            data_out_reg <= '0;
            valid_reg    <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sel_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= SCAN;
                    end
                end

                SCAN: begin
                    if (abort) begin
                        // Partial word is dropped; last completed word kept.
                        sel_reg   <= '0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (dwell_zero) begin
                        if (!last_ch) begin
                            sel_reg <= sel_reg + 1'b1;
                        end else begin
                            data_out_reg <= {y_in, shadow_reg};
                            valid_reg    <= 1'b1;
                            busy_reg     <= 1'b0;
                            state_reg    <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (bus.ready) begin
                        valid_reg <= 1'b0;
                        sel_reg   <= '0;
                        if (start) begin
                            busy_reg  <= 1'b1;
                            state_reg <= SCAN;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign sel          = sel_reg;
    assign busy         = busy_reg;
    assign bus.data_out = data_out_reg;
    assign bus.valid    = valid_reg;

endmodule
